// File: rtl/input_handshake_pkg.sv
// Shared definitions for the CPU input-instruction handshake: FSM state
// encoding, default debounce/synchronizer depths and data widths.
package input_handshake_pkg;

    localparam int DEB_CYCLES_DEFAULT  = 50000;
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int SW_W                = 10;
    localparam int DATA_W              = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        PRESS = 2'd2,
        DONE  = 2'd3
    } hs_state_t;

    // Zero-extend the switch bank onto the CPU data bus.
    function automatic logic [DATA_W-1:0] zext_sw(input logic [SW_W-1:0] v);
        return {{(DATA_W - SW_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/input_handshake_debounce.sv
// Synchronizer plus debouncer for an active-low pushbutton. Produces the
// debounced level (1 = released) and a one-cycle pulse on each accepted press.
module debounce
    import input_handshake_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic srst,
    input  logic raw,
    output logic level,
    output logic fall
);

    // A one-flop synchronizer is never acceptable, so clamp the depth at 2.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CNT_W  = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [SYNC_N-1:0] sync_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              level_reg;
    logic              fall_reg;
    logic              sync_level;

    assign sync_level = sync_reg[SYNC_N-1];
    assign level      = level_reg;
    assign fall       = fall_reg;

    // Shift the raw button through the synchronizer; reset to "released".
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_N-2:0], raw};
        end
    end

    // Count consecutive samples that disagree with the debounced level; the
    // level flips on the DEB_CYCLES-th one, any agreeing sample restarts.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg   <= '0;
            level_reg <= 1'b1;
            fall_reg  <= 1'b0;
        end else begin
            fall_reg <= 1'b0;
            if (sync_level != level_reg) begin
                if (cnt_reg >= CNT_LAST) begin
                    level_reg <= sync_level;
                    cnt_reg   <= '0;
                    fall_reg  <= ~sync_level;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

endmodule

// File: rtl/input_handshake.sv
// CPU Input-instruction handshake: waits for a fresh debounced press of
// Enter while req is pending, captures the switches and pulses ack.
module input_handshake
    import input_handshake_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              req,
    input  logic              Enter,
    input  logic [SW_W-1:0]   sw,
    output logic [DATA_W-1:0] data_out,
    output logic              ack,
    output logic              waiting
);

    hs_state_t         state_reg;
    logic [DATA_W-1:0] data_reg;
    logic              ack_reg;
    logic              waiting_reg;
    logic              need_low_reg;
    logic              deb_level;
    logic              deb_fall;

    debounce #(
        .DEB_CYCLES  (DEB_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_debounce (
        .clk   (CLK),
        .srst  (reset),
        .raw   (Enter),
        .level (deb_level),
        .fall  (deb_fall)
    );

    assign data_out = data_reg;
    assign ack      = ack_reg;
    assign waiting  = waiting_reg;

    // Handshake FSM with registered outputs. need_low_reg blocks re-arming
    // after an ack until req has been seen low for a cycle.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg    <= IDLE;
            data_reg     <= '0;
            ack_reg      <= 1'b0;
            waiting_reg  <= 1'b0;
            need_low_reg <= 1'b0;
        end else begin
            ack_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!req) begin
                        need_low_reg <= 1'b0;
                    end else if (!need_low_reg) begin
                        state_reg   <= ARM;
                        waiting_reg <= 1'b1;
                    end
                end
                ARM: begin
                    if (!req) begin
                        state_reg   <= IDLE;
                        waiting_reg <= 1'b0;
                    end else if (deb_level) begin
                        state_reg <= PRESS;
                    end
                end
                PRESS: begin
                    if (!req) begin
                        state_reg   <= IDLE;
                        waiting_reg <= 1'b0;
                    end else if (deb_fall) begin
                        data_reg    <= zext_sw(sw);
                        ack_reg     <= 1'b1;
                        waiting_reg <= 1'b0;
                        state_reg   <= DONE;
                    end
                end
                DONE: begin
                    state_reg    <= IDLE;
                    need_low_reg <= req;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/input_handshake.md
INPUT_HANDSHAKE -- requirements
Module: input_handshake

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 50000, meaning the number of consecutive stable synchronized samples required to accept a level change on Enter.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth for Enter, with a minimum of 2.
REQ-003 SHALL run on one clock; reset is synchronous and active-high.
REQ-004 CLK  input  1  system clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req  input  1  CPU Input instruction is pending; held high until ack is seen.
REQ-007 Enter  input  1  raw pushbutton, active-low (0 = pressed), asynchronous to CLK.
REQ-008 sw  input  10  raw slide switches, sampled only at capture.
REQ-009 data_out  output  32  captured switch value, zero-extended to 32 bits.
REQ-010 ack  output  1  one-cycle pulse: data_out is valid for this req.
REQ-011 waiting  output  1  high while req is pending and not yet acked; drives the CPU stall.

Function
REQ-012 Enter SHALL pass through a SYNC_STAGES flop synchronizer before any other use.
REQ-013 Debounce: the synchronized level SHALL change the debounced level only after DEB_CYCLES consecutive identical samples; any differing sample SHALL restart the counter at 0.
REQ-014 Counter width SHALL be $clog2(DEB_CYCLES+1), and the counter SHALL saturate with no wrap-around.
REQ-015 The FSM SHALL have the states IDLE, ARM, PRESS, DONE.
REQ-016 IDLE: on req=1, go to ARM.
REQ-017 ARM: wait until the debounced level is released (1).
- If the button is already held when req rises, it SHALL first be released; a press held from before req is never captured.
- Once released, go to PRESS.
REQ-018 PRESS: on a debounced falling edge (press), latch data_out <= {22'b0, sw} in that cycle and go to DONE.
REQ-019 DONE: assert ack for exactly one cycle, then return to IDLE; re-arming requires req to be low for at least 1 cycle.
REQ-020 waiting SHALL be high in ARM and PRESS, and low in IDLE and DONE.
REQ-021 If req falls while in ARM or PRESS, the FSM SHALL return to IDLE, with no ack and data_out unchanged.
REQ-022 Latency: ack SHALL rise exactly 1 cycle after the capture cycle, and data_out SHALL be stable from the capture cycle onward.
REQ-023 data_out SHALL hold its value until the next capture and SHALL NOT track sw at any other time.
REQ-024 Release timing SHALL be irrelevant once DONE is reached, and no second ack SHALL occur for the same press.
REQ-025 If req and a debounced press coincide in the same cycle from IDLE, no capture SHALL occur (the ARM rule applies).

Reset
REQ-026 On reset=1 at a CLK edge, the following SHALL be set:
- FSM = IDLE, data_out = 0, ack = 0, waiting = 0.
- Debounce counter = 0.
- Synchronizer flops and debounced level = 1 (released).
REQ-027 Reset asserted mid-operation SHALL abort with no ack pulse.
REQ-028 After reset is released, the block SHALL require DEB_CYCLES stable samples before recognizing any press.

Structure
REQ-029 The FSM state encoding (IDLE, ARM, PRESS, DONE) and the default DEB_CYCLES constant SHALL live in the shared CPU package.
REQ-030 Synchronizer plus debounce SHALL be one sub-module, named debounce, outputting the debounced level and a one-cycle fall pulse.
- input_handshake instantiates debounce and contains only the FSM and the capture register.

Verification (DEB_CYCLES=4)
REQ-031 Basic capture:
- Stimulus: sw=10'h2A5, req=1, then Enter low for 10 cycles.
- Required response: data_out=32'h000002A5, ack pulses once, waiting falls with ack.
REQ-032 Bounce rejection:
- Stimulus: Enter toggles every 2 cycles for 20 cycles, then stays high.
- Required response: no capture and no ack.
REQ-033 Pre-held button:
- Stimulus: Enter held low, then req=1, then release for 6 cycles, then press with sw=10'h3FF.
- Required response: exactly one capture, with data_out=32'h000003FF.
REQ-034 Abort:
- Stimulus: req dropped while in PRESS.
- Required response: state returns to IDLE, no ack, prior data_out retained.
REQ-035 Reset mid-operation:
- Stimulus: reset pulsed while in ARM with data_out=32'h15.
- Required response: data_out=0, waiting=0, no ack.
REQ-036 Back-to-back requests:
- Stimulus: two reqs separated by one low cycle, two presses with sw=10'h001 then 10'h002.
- Required response: two acks, data_out=1 then 2.
